// File: rtl/timer_bank_pkg.sv
// Shared definitions for the memory-mapped timer bank: CTRL bit positions,
// register word offsets, channel FSM encoding and the byte-lane merge helper.
package timer_bank_pkg;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MASK     = 3;
  localparam int CTRL_PEND     = 4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h7F00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] din,
                                             input logic [3:0]  be);
    byte_merge = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) byte_merge[8*b +: 8] = din[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT registers, the
// IDLE/LOAD/CNT/INT sequencer and the masked interrupt output.
module timer_bank_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [1:0]  reg_sel,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state, state_n;
  logic             en, mask, pend;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset, count;
  logic [31:0]      preset_merged;
  logic             ctrl_wr, preset_wr, en_next;
  logic             load, dec, expire, stop;

  assign ctrl_wr       = wr && (reg_sel == REG_CTRL) && byteen[0];
  assign preset_wr     = wr && (reg_sel == REG_PRESET);
  assign en_next       = ctrl_wr ? wdata[CTRL_EN] : en;
  assign preset_merged = byte_merge(32'(preset), wdata, byteen);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // PEND rises on the CNT->INT edge so it is visible for the whole INT cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_n = state;
    load    = 1'b0;
    dec     = 1'b0;
    expire  = 1'b0;
    stop    = 1'b0;
    unique case (state)
      ST_IDLE: if (en) state_n = ST_LOAD;
      ST_LOAD: begin
        load    = 1'b1;
        state_n = ST_CNT;
      end
      ST_CNT: begin
        if (!en)              state_n = ST_IDLE;
        else if (count > ONE) dec = 1'b1;
        else begin
          expire  = 1'b1;
          state_n = ST_INT;
        end
      end
      ST_INT: begin
        stop    = (mode != MODE_RELOAD);
        state_n = (mode == MODE_RELOAD && en_next) ? ST_LOAD : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      mask   <= 1'b0;
      pend   <= 1'b0;
      preset <= '0;
      count  <= '0;
    end else begin
      if (ctrl_wr) begin
        en   <= wdata[CTRL_EN];
        mode <= wdata[CTRL_MODE_LSB +: 2];
        mask <= wdata[CTRL_MASK];
      end
      if (stop) en <= 1'b0;
      // A terminal count in the same cycle as a W1C keeps the pending bit.
      if (expire)                           pend <= 1'b1;
      else if (ctrl_wr && wdata[CTRL_PEND]) pend <= 1'b0;
      if (preset_wr) preset <= preset_merged[CNT_W-1:0];
      if (load)        count <= preset;
      else if (dec)    count <= count - ONE;
      else if (expire) count <= '0;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_CTRL:   rdata = {27'd0, pend, mask, mode, en};
      REG_PRESET: rdata = 32'(preset);
      REG_COUNT:  rdata = 32'(count);
      default:    rdata = '0;
    endcase
  end

  assign irq = pend & mask;

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH memory-mapped timers on the CPU data bus: window decode,
// per-channel write strobes, read-back mux and interrupt reduction.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          CH_STRIDE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  output logic              hit,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam int          STRIDE_SH = $clog2(CH_STRIDE);
  localparam logic [31:0] WIN_BYTES = 32'(NUM_CH * CH_STRIDE);
  localparam logic [31:0] OFF_MASK  = 32'(CH_STRIDE - 1);

  logic [31:0]       off, ch_idx;
  logic              mapped;
  logic [NUM_CH-1:0] ch_wr;
  logic [31:0]       ch_rdata [NUM_CH];

  assign off    = addr - BASE_ADDR;
  assign hit    = (addr >= BASE_ADDR) && (off < WIN_BYTES);
  assign ch_idx = off >> STRIDE_SH;
  // Only the first four words of each stride hold registers; the rest RAZ/WI.
  assign mapped = hit && ((off & OFF_MASK) < 32'h10);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr[i] = mapped && (|byteen) && (ch_idx == 32'(i));

    timer_bank_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr      (ch_wr[i]),
      .reg_sel (off[3:2]),
      .byteen  (byteen),
      .wdata   (wdata),
      .rdata   (ch_rdata[i]),
      .irq     (irq[i])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mapped && (ch_idx == 32'(i))) rdata = ch_rdata[i];
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: a default bank and a 4-channel/16-bit bank
// share one bus; expected values go through a scoreboard queue.
module tb_timer_bank;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic [31:0] addr   = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] wdata  = '0;

  logic        hit0, hit1, irq_any0, irq_any1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  irq0;
  logic [3:0]  irq1;

  timer_bank dut0 (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .byteen  (byteen),
    .wdata   (wdata),
    .hit     (hit0),
    .rdata   (rdata0),
    .irq     (irq0),
    .irq_any (irq_any0)
  );

  timer_bank #(
    .NUM_CH    (4),
    .CNT_W     (16),
    .BASE_ADDR (32'h8000),
    .CH_STRIDE (32)
  ) dut1 (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .byteen  (byteen),
    .wdata   (wdata),
    .hit     (hit1),
    .rdata   (rdata1),
    .irq     (irq1),
    .irq_any (irq_any1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr   = a;
    byteen = be;
    wdata  = d;
    @(posedge clk);
    @(negedge clk);
    byteen = 4'h0;
  endtask

  task automatic rd(input string tag, input bit sel, input logic [31:0] a,
                    input logic [31:0] exp);
    push(tag, exp);
    addr   = a;
    byteen = 4'h0;
    #1;
    pop_cmp(sel ? rdata1 : rdata0);
  endtask

  task automatic hchk(input string tag, input bit sel, input logic [31:0] a, input logic exp);
    push(tag, {31'd0, exp});
    addr   = a;
    byteen = 4'h0;
    #1;
    pop_cmp({31'd0, sel ? hit1 : hit0});
  endtask

  task automatic sig(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    push(tag, exp);
    pop_cmp(obs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(1);
    sig("rst_irq", 32'h0, {30'd0, irq0});
    sig("rst_irq_any", 32'h0, {31'd0, irq_any0});
    rd("rst_ctrl0", 0, 32'h7F00, 32'h0);
    cyc(1);
    reset = 1'b1;
    cyc(1);

    // One-shot, PRESET=5: PEND/irq 7 edges after the EN write edge
    wr(32'h7F04, 4'hF, 32'd5);
    wr(32'h7F00, 4'hF, 32'h9);
    cyc(2);
    rd("os_count_loaded", 0, 32'h7F08, 32'd5);
    cyc(4);
    sig("os_irq_before", 32'h0, {30'd0, irq0});
    cyc(1);
    sig("os_irq_rise", 32'h1, {30'd0, irq0});
    cyc(1);
    rd("os_ctrl_en_off", 0, 32'h7F00, 32'h18);
    rd("os_count_zero", 0, 32'h7F08, 32'h0);
    sig("os_irq_any", 32'h1, {31'd0, irq_any0});
    wr(32'h7F00, 4'h1, 32'h18);
    sig("os_w1c_irq_any", 32'h0, {31'd0, irq_any0});

    // Auto-reload on ch1, PRESET=3: period 5
    wr(32'h7F14, 4'hF, 32'd3);
    wr(32'h7F10, 4'hF, 32'hB);
    cyc(4);
    sig("ar_irq_before", 32'h0, {30'd0, irq0});
    cyc(1);
    sig("ar_irq_first", 32'h2, {30'd0, irq0});
    wr(32'h7F10, 4'h1, 32'h1B);
    sig("ar_w1c_clear", 32'h0, {30'd0, irq0});
    cyc(3);
    sig("ar_irq_gap", 32'h0, {30'd0, irq0});
    cyc(1);
    sig("ar_irq_second", 32'h2, {30'd0, irq0});
    wr(32'h7F10, 4'h1, 32'h1B);
    sig("ar_w1c_clear2", 32'h0, {31'd0, irq_any0});
    cyc(3);

    // W1C on the same edge PEND sets: set wins
    wr(32'h7F10, 4'h1, 32'h1B);
    sig("race_irq", 32'h2, {30'd0, irq0});
    sig("race_irq_any", 32'h1, {31'd0, irq_any0});
    rd("race_ctrl", 0, 32'h7F10, 32'h1B);

    // EN=0 written during INT: channel stops, PEND stays
    wr(32'h7F10, 4'h1, 32'h0A);
    rd("stop_ctrl", 0, 32'h7F10, 32'h1A);
    sig("stop_irq", 32'h2, {30'd0, irq0});
    cyc(3);
    rd("stop_count_held", 0, 32'h7F18, 32'h0);

    // Async reset in the middle of a count
    wr(32'h7F00, 4'h1, 32'h9);
    cyc(3);
    rd("mid_count", 0, 32'h7F08, 32'd4);
    cyc(1);
    reset = 1'b0;
    #1;
    sig("arst_irq", 32'h0, {30'd0, irq0});
    sig("arst_irq_any", 32'h0, {31'd0, irq_any0});
    rd("arst_count0", 0, 32'h7F08, 32'h0);
    rd("arst_ctrl1", 0, 32'h7F10, 32'h0);
    rd("arst_preset0", 0, 32'h7F04, 32'h0);
    cyc(1);
    reset = 1'b1;
    rd("rel_ctrl0", 0, 32'h7F00, 32'h0);
    cyc(3);
    rd("rel_count0", 0, 32'h7F08, 32'h0);

    // Byte enables and ignored writes
    cyc(1);
    wr(32'h7F04, 4'b0010, 32'hFFFF_FFFF);
    rd("be_preset", 0, 32'h7F04, 32'h0000_FF00);
    wr(32'h7F08, 4'hF, 32'h1234);
    rd("count_ro", 0, 32'h7F08, 32'h0);
    wr(32'h7F0C, 4'hF, 32'hFFFF_FFFF);
    rd("rsvd_raz", 0, 32'h7F0C, 32'h0);
    wr(32'h7F00, 4'b0010, 32'hFFFF_FFFF);
    rd("ctrl_byte1_ignored", 0, 32'h7F00, 32'h0);

    // Window boundaries and the narrow 4-channel bank
    cyc(1);
    hchk("hit_past_end", 0, 32'h7F20, 1'b0);
    rd("rdata_past_end", 0, 32'h7F20, 32'h0);
    hchk("hit_last_byte", 0, 32'h7F1F, 1'b1);
    cyc(1);
    hchk("hit_below_base", 0, 32'h7EFF, 1'b0);
    hchk("hit1_base", 1, 32'h8000, 1'b1);
    hchk("hit0_other_bank", 0, 32'h8000, 1'b0);
    cyc(1);
    wr(32'h8064, 4'hF, 32'h0001_2345);
    rd("w16_preset_trunc", 1, 32'h8064, 32'h0000_2345);
    wr(32'h8070, 4'hF, 32'h1F);
    rd("stride_hole_raz", 1, 32'h8070, 32'h0);
    rd("stride_hole_wi", 1, 32'h8060, 32'h0);
    cyc(1);
    hchk("hit1_last_byte", 1, 32'h807F, 1'b1);
    hchk("hit1_past_end", 1, 32'h8080, 1'b0);
    rd("w16_ch2_preset", 1, 32'h8044, 32'h0);
    cyc(1);
    sig("w16_irq", 32'h0, {28'd0, irq1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
